// File: rtl/ex_muldiv_unit_pkg.sv
// Multiply/divide unit shared definitions:
// md op encodings and default latencies.
package md_defs;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic int md_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_counter.sv
// Latency countdown for the multiply/divide unit:
// loads a cycle count and pulses done on the 1->0 step.
module md_latency_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // High in the cycle whose closing edge takes the count to zero
  assign done = ~load & (cnt == CW'(1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models
// MULT/DIV latency and exposes busy plus MFHI/MFLO data.
module ex_muldiv_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  output logic               md_start,
  output logic               md_busy,
  output logic [31:0]        md_rdata,
  output logic [31:0]        hi_out,
  output logic [31:0]        lo_out
);

  localparam int MAX_LAT = md_max(MULT_CYCLES, DIV_CYCLES);
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

  logic is_mul, is_mulu, is_div, is_divu;
  logic is_div_any, is_start;

  assign is_mul     = (md_op == MD_MULT);
  assign is_mulu    = (md_op == MD_MULTU);
  assign is_div     = (md_op == MD_DIV);
  assign is_divu    = (md_op == MD_DIVU);
  assign is_div_any = is_div | is_divu;
  assign is_start   = is_mul | is_mulu | is_div_any;

  assign md_start = enable & ~md_busy & is_start;

  logic [63:0] a_ext, b_ext, prod;

  // Sign-extension makes the low 64 bits of the product correct for MULT
  assign a_ext = {{32{is_mul & rs_val[31]}}, rs_val};
  assign b_ext = {{32{is_mul & rt_val[31]}}, rt_val};
  assign prod  = a_ext * b_ext;

  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quo, rem;

  // Magnitude division keeps 0x80000000 / -1 well defined
  assign a_neg    = is_div & rs_val[31];
  assign b_neg    = is_div & rt_val[31];
  assign a_mag    = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag    = b_neg ? (32'd0 - rt_val) : rt_val;
  assign div_zero = (rt_val == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [31:0] res_hi, res_lo;

  assign res_hi = is_div_any ? rem : prod[63:32];
  assign res_lo = is_div_any ? quo : prod[31:0];

  logic done;

  md_latency_counter #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_start),
    .load_val (is_div_any ? DIV_LAT : MUL_LAT),
    .done     (done)
  );

  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
  logic        pend_keep;
  logic        mt_ok;

  assign mt_ok = enable & ~md_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_busy   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_keep <= 1'b0;
    end else begin
      if (md_start) begin
        pend_hi   <= res_hi;
        pend_lo   <= res_lo;
        pend_keep <= is_div_any & div_zero;
        md_busy   <= 1'b1;
      end else if (done) begin
        md_busy <= 1'b0;
        if (!pend_keep) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end
      if (mt_ok && md_op == MD_MTHI) hi_q <= rs_val;
      if (mt_ok && md_op == MD_MTLO) lo_q <= rs_val;
    end
  end

  always_comb begin
    md_rdata = '0;
    unique case (1'b1)
      (md_op == MD_MFHI): md_rdata = hi_q;
      (md_op == MD_MFLO): md_rdata = lo_q;
      default:            md_rdata = '0;
    endcase
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed cases then
// random ops against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_start, md_busy;
  logic [31:0] md_rdata, hi_out, lo_out;

  int total = 0;
  int bad = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_keep;
  int          left;

  ex_muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_rdata (md_rdata),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start_op(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU ||
           op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV:   return {32'(sa % sb), 32'(sa / sb)};
      default:  return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic step(input bit rst, input bit en, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    bit exp_start;
    logic [31:0] exp_rd;
    logic [63:0] r;
    reset = rst; enable = en; md_op = op; rs_val = a; rt_val = b;
    #1;
    exp_start = en && left == 0 && is_start_op(op);
    exp_rd = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
    chk("md_start", {31'd0, md_start}, {31'd0, exp_start});
    chk("md_rdata", md_rdata, exp_rd);
    @(posedge clk);
    #1;
    if (rst) begin
      m_hi = 0; m_lo = 0; left = 0; p_keep = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0 && !p_keep) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (exp_start) begin
      p_keep = (op == MD_DIV || op == MD_DIVU) && b == 0;
      if (!p_keep) begin
        r = ref_res(op, a, b);
        p_hi = r[63:32]; p_lo = r[31:0];
      end
      left = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
    end else if (en && op == MD_MTHI) begin
      m_hi = a;
    end else if (en && op == MD_MTLO) begin
      m_lo = a;
    end
    chk("md_busy", {31'd0, md_busy}, {31'd0, left > 0});
    chk("hi_out", hi_out, m_hi);
    chk("lo_out", lo_out, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, MD_NONE, 0, 0);
  endtask

  initial begin
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_keep = 0; left = 0;
    step(1, 0, MD_NONE, 0, 0);
    step(1, 0, MD_NONE, 0, 0);
    chk("reset_hi", hi_out, 32'd0);
    step(0, 1, MD_MFHI, 0, 0);

    step(0, 1, MD_MULT, 32'd3, 32'hFFFFFFFE);
    idle(5);
    chk("mult_hi", hi_out, 32'hFFFFFFFF);
    chk("mult_lo", lo_out, 32'hFFFFFFFA);
    step(0, 1, MD_MULTU, 32'd3, 32'hFFFFFFFE);
    idle(5);
    chk("multu_hi", hi_out, 32'h00000002);
    step(0, 1, MD_DIV, 32'hFFFFFFF9, 32'd2);
    idle(10);
    chk("div_lo", lo_out, 32'hFFFFFFFD);
    chk("div_hi", hi_out, 32'hFFFFFFFF);
    step(0, 1, MD_DIVU, 32'd7, 32'd2);
    idle(10);
    chk("divu_lo", lo_out, 32'd3);
    step(0, 1, MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("ovf_lo", lo_out, 32'h80000000);
    chk("ovf_hi", hi_out, 32'd0);

    step(0, 1, MD_MTHI, 32'h12345678, 0);
    step(0, 1, MD_DIV, 32'd5, 32'd0);
    idle(10);
    chk("dz_hi", hi_out, 32'h12345678);
    chk("dz_lo", lo_out, 32'h80000000);

    step(0, 1, MD_MULT, 32'd7, 32'd9);
    step(0, 1, MD_MULT, 32'd100, 32'd100);
    step(0, 1, MD_MTHI, 32'hAAAA5555, 0);
    step(0, 0, MD_DIV, 32'd1, 32'd1);
    idle(2);
    step(0, 0, MD_MULT, 32'd2, 32'd2);
    step(0, 1, MD_MFLO, 0, 0);
    chk("busy_ign_lo", lo_out, 32'd63);

    step(0, 1, MD_MULT, 32'd11, 32'd13);
    idle(2);
    step(1, 1, MD_NONE, 0, 0);
    chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    idle(6);
    chk("rst_no_commit", lo_out, 32'd0);

    step(0, 1, MD_MTLO, 32'hDEADBEEF, 0);
    step(0, 1, MD_MFLO, 0, 0);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b;
      a = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
      case ($urandom % 8)
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom % 16;
        default: b = $urandom;
      endcase
      step($urandom % 80 == 0, $urandom % 4 != 0,
           4'($urandom % 9), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
